// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: instruction descriptor in, forward selects and stall out.
// The master drives the ID instruction; the slave (scoreboard) answers combinationally.
interface hazard_scoreboard_if #(
   parameter int unsigned STAGES = 3,
   parameter int unsigned AREG   = 5,
   parameter int unsigned NSRC   = 2,
   parameter int unsigned SELW   = 3
);
   logic                   id_valid;
   logic [NSRC*AREG-1:0]   id_src;
   logic [NSRC-1:0]        id_src_used;
   logic [AREG-1:0]        id_dst;
   logic                   id_wr;
   logic                   id_load;
   logic                   id_flush;
   logic                   stall;
   logic [NSRC*SELW-1:0]   fwd_sel;
   logic [STAGES-1:0]      busy_mask;

   modport master (
      output id_valid, id_src, id_src_used, id_dst, id_wr, id_load, id_flush,
      input  stall, fwd_sel, busy_mask
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_dst, id_wr, id_load, id_flush,
      output stall, fwd_sel, busy_mask
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline write scoreboard: per-operand forward selects and load-use stall for ID.
// Optional HAZARD_STALL_CNT_EN adds a saturating 32-bit stall cycle counter.
module hazard_scoreboard #(
   parameter int unsigned STAGES     = 3,
   parameter int unsigned AREG       = 5,
   parameter int unsigned NSRC       = 2,
   parameter int unsigned LOAD_STAGE = 1,
   parameter int unsigned SELW       = 3
) (
   input  logic               clk,
   input  logic               reset,
   hazard_scoreboard_if.slave idBus
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]        stall_cnt
`endif
);

   localparam int unsigned CNTW = 32;

   typedef struct packed {
      logic            v;
      logic            wr;
      logic            ld;
      logic [AREG-1:0] dst;
   } entryT;

   entryT               entries [STAGES];
   entryT               newEntry;
   logic [STAGES-1:0]   live;
   logic [STAGES-1:0]   busyMask;
   logic [NSRC-1:0]     opHaz;
   logic [NSRC*SELW-1:0] selRaw;
   logic [NSRC*SELW-1:0] fwdSel;
   logic                stallNow;
   logic                accept;

   // Live entries are the ones that will actually update a non-zero register.
   always_comb begin
      live     = '0;
      busyMask = '0;
      for (int k = 0; k < int'(STAGES); k++) begin
         busyMask[k] = entries[k].v && entries[k].wr;
         live[k]     = busyMask[k] && (entries[k].dst != '0);
      end
   end

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      opHaz  = '0;
      selRaw = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (idBus.id_src_used[i]) begin
            for (int k = int'(STAGES) - 1; k >= 0; k--) begin
               if (live[k] && (entries[k].dst == idBus.id_src[i*AREG +: AREG])) begin
                  selRaw[i*SELW +: SELW] = SELW'(k + 1);
                  opHaz[i]               = entries[k].ld && (k < int'(LOAD_STAGE));
               end
            end
         end
      end
   end

   // Flush and reset both override a pending load-use hazard.
   always_comb begin
      stallNow = !reset && idBus.id_valid && !idBus.id_flush && (|opHaz);
      fwdSel   = selRaw;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (stallNow && opHaz[i]) begin
            fwdSel[i*SELW +: SELW] = '0;
         end
      end
   end

   always_comb begin
      accept   = idBus.id_valid && !idBus.id_flush && !stallNow;
      newEntry = '0;
      if (accept) begin
         newEntry.v   = 1'b1;
         newEntry.wr  = idBus.id_wr;
         newEntry.ld  = idBus.id_load;
         newEntry.dst = idBus.id_dst;
      end
   end

   assign idBus.stall     = stallNow;
   assign idBus.fwd_sel   = fwdSel;
   assign idBus.busy_mask = busyMask;

   // Older entries always advance; a stall only replaces the incoming entry with a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            entries[k] <= '0;
         end
      end else begin
         entries[0] <= newEntry;
         for (int k = 1; k < int'(STAGES); k++) begin
            entries[k] <= entries[k-1];
         end
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [CNTW-1:0] stallCnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt <= '0;
      end else if (stallNow && (stallCnt != '1)) begin
         stallCnt <= stallCnt + CNTW'(1);
      end
   end

   assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed test of hazard_scoreboard: forwarding, load-use stall, $0, flush and reset.
module tb_hazard_scoreboard;

   localparam int unsigned STAGES     = 3;
   localparam int unsigned AREG       = 5;
   localparam int unsigned NSRC       = 2;
   localparam int unsigned LOAD_STAGE = 1;
   localparam int unsigned SELW       = 3;

   logic clk;
   logic reset;
   int   testsRun;
   int   testsFailed;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stallCnt;
`endif

   hazard_scoreboard_if #(.STAGES(STAGES), .AREG(AREG), .NSRC(NSRC), .SELW(SELW)) bus ();

   hazard_scoreboard #(
      .STAGES(STAGES), .AREG(AREG), .NSRC(NSRC), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .idBus (bus)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stall_cnt (stallCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [AREG-1:0] s0, input logic [AREG-1:0] s1,
                        input logic [1:0] used, input logic [AREG-1:0] dst,
                        input logic wr, input logic ld, input logic flush);
      bus.id_valid    = v;
      bus.id_src      = {s1, s0};
      bus.id_src_used = used;
      bus.id_dst      = dst;
      bus.id_wr       = wr;
      bus.id_load     = ld;
      bus.id_flush    = flush;
      #2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 3; n++) begin
         drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
         step();
      end
   endtask

   function automatic logic [SELW-1:0] fwd(input int i);
      logic [NSRC*SELW-1:0] all;
      all = bus.fwd_sel;
      return all[i*SELW +: SELW];
   endfunction

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b0;

      // Empty scoreboard
      drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("rst_stall", 32'(bus.stall), 32'd0);
      checkEq("rst_fwd0", 32'(fwd(0)), 32'd0);
      checkEq("rst_fwd1", 32'(fwd(1)), 32'd0);
      checkEq("rst_busy", 32'(bus.busy_mask), 32'b000);
      step();

      // ALU forwarding from EX then MEM
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd8, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("ex_fwd0", 32'(fwd(0)), 32'd1);
      checkEq("ex_fwd1", 32'(fwd(1)), 32'd0);
      checkEq("ex_stall", 32'(bus.stall), 32'd0);
      checkEq("ex_busy", 32'(bus.busy_mask), 32'b001);
      drive(1'b1, 5'd9, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("ex_op1_fwd1", 32'(fwd(1)), 32'd1);
      drive(1'b1, 5'd8, 5'd8, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("unused_fwd1", 32'(fwd(1)), 32'd0);
      checkEq("used_fwd0", 32'(fwd(0)), 32'd1);
      step();
      drive(1'b1, 5'd8, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("mem_fwd0", 32'(fwd(0)), 32'd2);
      checkEq("mem_busy", 32'(bus.busy_mask), 32'b010);
      step();
      drain();
      checkEq("drain_busy", 32'(bus.busy_mask), 32'b000);

      // Load-use: one stall cycle, then forward from MEM
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
      checkEq("lu_stall", 32'(bus.stall), 32'd1);
      checkEq("lu_fwd0", 32'(fwd(0)), 32'd0);
      checkEq("lu_busy", 32'(bus.busy_mask), 32'b001);
      step();
      checkEq("lu_stall2", 32'(bus.stall), 32'd0);
      checkEq("lu_fwd0b", 32'(fwd(0)), 32'd2);
      checkEq("lu_busy2", 32'(bus.busy_mask), 32'b010);
      step();
      drain();

      // Youngest match: load shadows an older ALU write of the same register
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd7, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("ym_stall", 32'(bus.stall), 32'd1);
      checkEq("ym_busy", 32'(bus.busy_mask), 32'b011);
      step();
      checkEq("ym_stall2", 32'(bus.stall), 32'd0);
      checkEq("ym_fwd0", 32'(fwd(0)), 32'd2);
      checkEq("ym_busy2", 32'(bus.busy_mask), 32'b110);
      step();
      drain();

      // Register $0 never forwards or stalls
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("r0_fwd0", 32'(fwd(0)), 32'd0);
      checkEq("r0_fwd1", 32'(fwd(1)), 32'd0);
      checkEq("r0_stall", 32'(bus.stall), 32'd0);
      step();
      drain();

      // Flush beats load-use hazard; a bubble enters
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b1);
      checkEq("fl_stall", 32'(bus.stall), 32'd0);
      step();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("fl_busy", 32'(bus.busy_mask), 32'b010);
      drain();

      // Reset during a stall drops it immediately and clears all entries
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
      checkEq("rs_pre", 32'(bus.stall), 32'd1);
      reset = 1'b1;
      #1;
      checkEq("rs_stall", 32'(bus.stall), 32'd0);
      step();
      reset = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      checkEq("rs_busy", 32'(bus.busy_mask), 32'b000);

`ifdef HAZARD_STALL_CNT_EN
      checkEq("cnt_rst", stallCnt, 32'd0);
      for (int n = 0; n < 5; n++) begin
         drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
         step();
         drive(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
         step();
         step();
      end
      drain();
      checkEq("cnt_five", stallCnt, 32'd5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkEq("cnt_clear", stallCnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
